// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined RV32I control unit: opcodes, control-word
// field positions, ASel encodings and the opcode decode table.
package ctrl_pkg;

  localparam int CTRL_W = 12;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int CB_JUMP_REG  = 11;
  localparam int CB_JUMP      = 10;
  localparam int CB_ASEL_LO   = 8;
  localparam int CB_ALU_SRC   = 7;
  localparam int CB_MEM_TO_REG = 6;
  localparam int CB_REG_WRITE = 5;
  localparam int CB_MEM_READ  = 4;
  localparam int CB_MEM_WRITE = 3;
  localparam int CB_BRANCH    = 2;
  localparam int CB_ALU_OP_LO = 0;

  localparam logic [1:0] ASEL_RS1  = 2'b00;
  localparam logic [1:0] ASEL_PC   = 2'b01;
  localparam logic [1:0] ASEL_ZERO = 2'b10;

  typedef struct packed {
    logic [11:0] word;
    logic        legal;
    logic        rs1_used;
    logic        rs2_used;
  } dec_t;

  // Word layout: {JumpReg, Jump, ASel[1:0], ALUSrc, MemtoReg, RegWrite,
  //               MemRead, MemWrite, Branch, ALUOp[1:0]}
  function automatic dec_t decode_op(input logic [6:0] op);
    dec_t d;
    d          = '0;
    d.legal    = 1'b1;
    d.rs1_used = 1'b1;
    case (op)
      OP_R:      begin d.word = {2'b00, ASEL_RS1,  8'b0010_0010}; d.rs2_used = 1'b1; end
      OP_I_ALU:        d.word = {2'b00, ASEL_RS1,  8'b1010_0011};
      OP_LOAD:         d.word = {2'b00, ASEL_RS1,  8'b1111_0000};
      OP_STORE:  begin d.word = {2'b00, ASEL_RS1,  8'b1000_1000}; d.rs2_used = 1'b1; end
      OP_BRANCH: begin d.word = {2'b00, ASEL_RS1,  8'b0000_0101}; d.rs2_used = 1'b1; end
      OP_JAL:    begin d.word = {2'b01, ASEL_RS1,  8'b0010_0000}; d.rs1_used = 1'b0; end
      OP_JALR:         d.word = {2'b11, ASEL_RS1,  8'b1010_0000};
      OP_LUI:    begin d.word = {2'b00, ASEL_ZERO, 8'b1010_0000}; d.rs1_used = 1'b0; end
      OP_AUIPC:  begin d.word = {2'b00, ASEL_PC,   8'b1010_0000}; d.rs1_used = 1'b0; end
      default:   begin d.legal = 1'b0; d.rs1_used = 1'b0; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decode: control word, illegal-opcode flag and
// source-register usage for the hazard detector.
module ctrl_decode #(
  parameter int CTRL_W         = 12,
  parameter bit ILLEGAL_BUBBLE = 1'b1
) (
  input  logic [6:0]        id_opcode_i,
  input  logic              id_valid_i,
  output logic [CTRL_W-1:0] id_ctrl_o,
  output logic              id_illegal_o,
  output logic              rs1_used_o,
  output logic              rs2_used_o
);
  import ctrl_pkg::*;

  dec_t dec;

  always_comb begin
    dec          = decode_op(id_opcode_i);
    id_ctrl_o    = '0;
    id_illegal_o = 1'b0;
    rs1_used_o   = 1'b0;
    rs2_used_o   = 1'b0;
    if (id_valid_i) begin
      id_illegal_o = ~dec.legal;
      rs1_used_o   = dec.rs1_used;
      rs2_used_o   = dec.rs2_used;
      if (dec.legal)
        id_ctrl_o = CTRL_W'(dec.word);
      else if (!ILLEGAL_BUBBLE)
        id_ctrl_o = 'x;
    end
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use / flush / freeze hazard control and saturating perf counters.
module ctrl_pipe_unit #(
  parameter int CTRL_W         = 12,
  parameter int REG_AW         = 5,
  parameter int CNT_W          = 16,
  parameter bit ILLEGAL_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       id_instr_i,
  input  logic              id_valid_i,
  input  logic              ex_branch_taken_i,
  input  logic              ext_stall_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              if_flush_o,
  output logic [CTRL_W-1:0] id_ctrl_o,
  output logic              id_illegal_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [CTRL_W-1:0] mem_ctrl_o,
  output logic [CTRL_W-1:0] wb_ctrl_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [REG_AW-1:0] mem_rd_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  illegal_cnt_o
);
  import ctrl_pkg::*;

  logic              rs1_used, rs2_used;
  logic [REG_AW-1:0] id_rd, id_rs1, id_rs2;
  logic              flush, load_use, bubble;
  logic              unused_instr_bits;

  assign id_rd             = REG_AW'(id_instr_i[11:7]);
  assign id_rs1            = REG_AW'(id_instr_i[19:15]);
  assign id_rs2            = REG_AW'(id_instr_i[24:20]);
  assign unused_instr_bits = ^{id_instr_i[31:25], id_instr_i[14:12]};

  ctrl_decode #(
    .CTRL_W         (CTRL_W),
    .ILLEGAL_BUBBLE (ILLEGAL_BUBBLE)
  ) u_decode (
    .id_opcode_i  (id_instr_i[6:0]),
    .id_valid_i   (id_valid_i),
    .id_ctrl_o    (id_ctrl_o),
    .id_illegal_o (id_illegal_o),
    .rs1_used_o   (rs1_used),
    .rs2_used_o   (rs2_used)
  );

  assign flush    = ex_branch_taken_i;
  assign load_use = ex_ctrl_o[CB_MEM_READ] & (ex_rd_o != '0) & id_valid_i &
                    ((rs1_used & (id_rs1 == ex_rd_o)) | (rs2_used & (id_rs2 == ex_rd_o)));
  // Load-use only takes effect when neither a flush nor a freeze overrides it.
  assign bubble   = load_use & ~flush & ~ext_stall_i;

  always_comb begin
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    if_flush_o   = 1'b0;
    if (rst_n) begin
      if (flush) begin
        if_flush_o = 1'b1;
      end else if (ext_stall_i || bubble) begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
      end
    end
  end

  // A flush wins over a freeze so the taken branch still advances into EX/MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_o  <= '0;
      mem_ctrl_o <= '0;
      wb_ctrl_o  <= '0;
      ex_rd_o    <= '0;
      mem_rd_o   <= '0;
      wb_rd_o    <= '0;
    end else if (flush || !ext_stall_i) begin
      ex_ctrl_o  <= (flush || bubble) ? '0 : id_ctrl_o;
      ex_rd_o    <= (flush || bubble) ? '0 : id_rd;
      mem_ctrl_o <= ex_ctrl_o;
      mem_rd_o   <= ex_rd_o;
      wb_ctrl_o  <= mem_ctrl_o;
      wb_rd_o    <= mem_rd_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
      illegal_cnt_o <= '0;
    end else begin
      if (bubble && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      if (id_illegal_o && !flush && !ext_stall_i && !bubble && illegal_cnt_o != '1)
        illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);
    end
  end

endmodule
